// File: rtl/rps_arbiter_n_if.sv
// Handshake bundle between requesters and the N-way rotating arbiter.
// master: drives en/mode/req/lock; slave: returns gnt/gnt_valid/gnt_id/req_up/ptr.
interface rps_arbiter_n_if #(
  parameter int N     = 8,
  parameter int PTR_W = $clog2(N)
);
  logic             en;
  logic             mode;
  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [PTR_W-1:0] gnt_id;
  logic             req_up;
  logic [PTR_W-1:0] ptr;

  modport master (
    output en, mode, req, lock,
    input  gnt, gnt_valid, gnt_id, req_up, ptr
  );

  modport slave (
    input  en, mode, req, lock,
    output gnt, gnt_valid, gnt_id, req_up, ptr
  );
endinterface

// File: rtl/rps_arbiter_n.sv
// N-way rotating-priority arbiter with per-requester grant lock.
// Ports: clock, reset (sync, active-high), bus (slave: en/mode/req/lock in; gnt/gnt_valid/gnt_id/req_up/ptr out).
module rps_arbiter_n #(
  parameter int N = 8,
  localparam int PTR_W = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  rps_arbiter_n_if.slave bus
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic             locked_q, locked_d;

  logic             hold;
  logic             found;
  logic [PTR_W-1:0] win;
  logic             sel_v;
  logic [PTR_W-1:0] sel_id;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end

  // Priority scan starting at ptr; index wraps naturally at PTR_W bits.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      logic [PTR_W-1:0] idx;
      idx = ptr_q + PTR_W'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    hold = locked_q & bus.en
         & bus.req[owner_q] & bus.lock[owner_q];
    sel_v  = 1'b0;
    sel_id = '0;
    if (!bus.en) begin
      sel_v  = 1'b0;
      sel_id = '0;
    end else if (hold) begin
      sel_v  = 1'b1;
      sel_id = owner_q;
    end else if (found) begin
      sel_v  = 1'b1;
      sel_id = win;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    locked_d = 1'b0;
    if (bus.en && sel_v && bus.lock[sel_id]) begin
      locked_d = 1'b1;
      owner_d  = sel_id;
    end
    if (!bus.mode) begin
      ptr_d = ptr_q + PTR_W'(1);
    end else if (sel_v && !hold) begin
      ptr_d = sel_id + PTR_W'(1);
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (sel_v) begin
      bus.gnt[sel_id] = 1'b1;
    end
    bus.gnt_valid = sel_v;
    bus.gnt_id    = sel_id;
    bus.req_up    = bus.en & (|bus.req);
    bus.ptr       = ptr_q;
  end

endmodule

// File: tb/tb_rps_arbiter_n.sv
// Directed self-checking bench for rps_arbiter_n (N=8).
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.
module tb_rps_arbiter_n;

  localparam int N = 8;

  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  rps_arbiter_n_if #(.N(N)) bus ();

  rps_arbiter_n #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic mode,
                       input logic [7:0] req,
                       input logic [7:0] lock);
    bus.en   = en;
    bus.mode = mode;
    bus.req  = req;
    bus.lock = lock;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g,
                         input logic [2:0] id, input logic [2:0] p);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, "_vld"}, 32'(bus.gnt_valid), 32'(g != 0));
    chk({tag, "_id"},  32'(bus.gnt_id), 32'(id));
    chk({tag, "_up"},  32'(bus.req_up), 32'(bus.en & (bus.req != 0)));
    chk({tag, "_ptr"}, 32'(bus.ptr), 32'(p));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;

    do_reset();
    chk_out("rst", 8'h00, 3'd0, 3'd0);

    // Two requesters alternate under round-robin.
    drive(1'b1, 1'b1, 8'h81, 8'h00);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) chk_out("rr81", 8'h01, 3'd0, 3'd0);
      else            chk_out("rr81", 8'h80, 3'd7, 3'd1);
      tick();
    end

    // Free-running rotation walks all eight and wraps.
    do_reset();
    drive(1'b1, 1'b0, 8'hFF, 8'h00);
    for (int k = 0; k < 9; k++) begin
      chk_out("rot", 8'(1 << (k % 8)), 3'(k % 8), 3'(k % 8));
      tick();
    end

    // Lock held by requester 1, then released by dropping req.
    do_reset();
    drive(1'b1, 1'b1, 8'h06, 8'h02);
    chk_out("lk0", 8'h02, 3'd1, 3'd0);
    tick();
    for (int k = 1; k < 5; k++) begin
      chk_out("lkh", 8'h02, 3'd1, 3'd2);
      tick();
    end
    drive(1'b1, 1'b1, 8'h04, 8'h02);
    chk_out("lkrel", 8'h04, 3'd2, 3'd2);
    tick();
    chk("lkrel_ptr", 32'(bus.ptr), 32'd3);
    drive(1'b1, 1'b1, 8'h06, 8'h02);
    chk_out("lknew", 8'h02, 3'd1, 3'd3);
    tick();
    chk("lknew_ptr", 32'(bus.ptr), 32'd2);

    // en=0 during a hold clears the lock.
    do_reset();
    drive(1'b1, 1'b1, 8'h06, 8'h02);
    tick();
    chk_out("en_h", 8'h02, 3'd1, 3'd2);
    tick();
    drive(1'b0, 1'b1, 8'h06, 8'h02);
    chk_out("en_off", 8'h00, 3'd0, 3'd2);
    tick();
    drive(1'b1, 1'b1, 8'h06, 8'h02);
    chk_out("en_on", 8'h04, 3'd2, 3'd2);
    tick();
    chk("en_on_ptr", 32'(bus.ptr), 32'd3);

    // Reset in the middle of a hold by requester 5.
    do_reset();
    drive(1'b1, 1'b1, 8'h20, 8'h20);
    chk_out("mh", 8'h20, 3'd5, 3'd0);
    tick();
    chk_out("mh_hold", 8'h20, 3'd5, 3'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b1, 8'h30, 8'h20);
    chk_out("post_rst", 8'h10, 3'd4, 3'd0);
    tick();
    chk("post_rst_ptr", 32'(bus.ptr), 32'd5);

    // Idle round-robin keeps ptr; idle rotate still advances.
    do_reset();
    drive(1'b1, 1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      chk_out("idle", 8'h00, 3'd0, 3'd0);
      tick();
    end
    drive(1'b1, 1'b1, 8'h08, 8'h00);
    chk_out("req3", 8'h08, 3'd3, 3'd0);
    tick();
    chk("req3_ptr", 32'(bus.ptr), 32'd4);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    tick();
    chk("rot_idle1", 32'(bus.ptr), 32'd5);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("rot_idle2", 32'(bus.ptr), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
